// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   state_e   : loader FSM states (ST_HDR..ST_ERR)
//   imem_wr_t : imem write payload (byte address + data word)
package imem_boot_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot loader bus: byte-stream input handshake, imem write port and core control.
//   start/in_valid/in_data : stream side, driven by the source
//   in_ready               : loader accepts a byte on in_valid && in_ready
//   we/wa/wd               : imem write strobe, byte address, data
//   core_rst_n/done/err    : core reset and load status
interface imem_boot_loader_if;
  import imem_boot_loader_pkg::*;

  logic              start;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WORD_W-1:0] wd;
  logic              core_rst_n;
  logic              done;
  logic              err;

  // Loader side
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, we, wa, wd, core_rst_n, done, err
  );

  // Stream source / memory / observer side
  modport master (
    output start, in_valid, in_data,
    input  in_ready, we, wa, wd, core_rst_n, done, err
  );

endinterface

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Little-endian byte-to-word assembler: bytes shift in from the top, first byte ends in [7:0].
//   clk, rst       : clock, synchronous active-high reset
//   i_clr          : clear counter and partial word
//   i_shift_en     : accept i_byte_in this cycle
//   o_word_out_c   : word as it would be after shifting i_byte_in in (valid with o_word_full_c)
//   o_word_full_c  : this shift completes a 4-byte word
module imem_boot_loader_byte_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_shift_en,
  input  logic [BYTE_W-1:0] i_byte_in,
  output logic [WORD_W-1:0] o_word_out_c,
  output logic              o_word_full_c
);

  // Only the three most recent bytes need storing; the fourth arrives on i_byte_in.
  logic [WORD_W-BYTE_W-1:0] r_low;
  logic [BCNT_W-1:0]        r_cnt;

  assign o_word_out_c  = {i_byte_in, r_low};
  assign o_word_full_c = i_shift_en && (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));

  // Shift register and byte counter; counter wraps 3->0 on the fourth byte
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_low <= '0;
      r_cnt <= '0;
    end else if (i_shift_en) begin
      r_low <= o_word_out_c[WORD_W-1:BYTE_W];
      r_cnt <= r_cnt + BCNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: takes a framed byte stream (LE word count N, then N
// LE words), writes the words to sequential imem addresses and holds the core in reset
// until the image is loaded.
//   clk, rst : clock, synchronous active-high reset
//   bus      : imem_boot_loader_if.slave (stream handshake, imem write port, status)
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  imem_boot_loader_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH + 1);

  state_e            r_state;
  state_e            w_next_state;
  logic              r_in_ready;
  logic              r_we;
  logic              r_core_rst_n;
  logic              r_done;
  logic              r_err;
  imem_wr_t          r_wr;
  logic [IDX_W-1:0]  r_word_idx;
  logic [IDX_W-1:0]  r_n;

  logic              w_accept;
  logic              w_word_full;
  logic [WORD_W-1:0] w_word;
  logic              w_hdr_bad;
  logic              w_restart;
  logic              w_load_n;
  logic              w_load_wr;
  logic              w_idx_inc;

  assign w_accept  = bus.in_valid && r_in_ready;
  // Compare the full 32-bit count so large headers cannot alias into range
  assign w_hdr_bad = (w_word == '0) || (w_word > WORD_W'(DEPTH));

  imem_boot_loader_byte_word_assembler u_asm (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_restart),
    .i_shift_en    (w_accept),
    .i_byte_in     (bus.in_data),
    .o_word_out_c  (w_word),
    .o_word_full_c (w_word_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_HDR;
    else     r_state <= w_next_state;
  end

  // Next-state and datapath control
  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_load_n     = 1'b0;
    w_load_wr    = 1'b0;
    w_idx_inc    = 1'b0;
    unique case (r_state)
      ST_HDR: begin
        if (w_word_full) begin
          w_load_n     = 1'b1;
          w_next_state = w_hdr_bad ? ST_ERR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_full) begin
          w_load_wr    = 1'b1;
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_idx_inc    = 1'b1;
        w_next_state = (r_word_idx == r_n - IDX_W'(1)) ? ST_DONE : ST_DATA;
      end
      ST_DONE, ST_ERR: begin
        if (bus.start) begin
          w_restart    = 1'b1;
          w_next_state = ST_HDR;
        end
      end
      default: w_next_state = ST_HDR;
    endcase
  end

  // Output registers follow the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready   <= 1'b1;
      r_we         <= 1'b0;
      r_wr         <= '{addr: BASE_ADDR, data: '0};
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_idx   <= '0;
      r_n          <= '0;
    end else begin
      r_in_ready   <= (w_next_state == ST_HDR) || (w_next_state == ST_DATA);
      r_we         <= (w_next_state == ST_WRITE);
      r_core_rst_n <= (w_next_state == ST_DONE);
      r_done       <= (w_next_state == ST_DONE);
      r_err        <= (w_next_state == ST_ERR);
      if (w_load_n) r_n <= IDX_W'(w_word);
      if (w_load_wr) begin
        r_wr.addr <= BASE_ADDR + (ADDR_W'(r_word_idx) << 2);
        r_wr.data <= w_word;
      end
      if (w_idx_inc)      r_word_idx <= r_word_idx + IDX_W'(1);
      else if (w_restart) r_word_idx <= '0;
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.we         = r_we;
  assign bus.wa         = r_wr.addr;
  assign bus.wd         = r_wr.data;
  assign bus.core_rst_n = r_core_rst_n;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (base 0x0 and 0x100) share one stimulus;
// a frame-level reference model predicts status and writes every cycle.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;

  typedef struct {
    logic [31:0] hdr;
    logic        exp_err;
  } hdr_vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  int checks = 0;
  int errors = 0;
  bit rnd_start_en = 1'b0;

  logic [63:0] wr_log[$];
  logic [31:0] last_wa1;

  // Reference model: frame-level counters
  int          m_nbytes;
  logic [31:0] m_acc;
  bit          m_have_hdr;
  int          m_n;
  int          m_words;
  bit          m_wr_now;
  logic [31:0] m_wd;
  bit          m_done;
  bit          m_err;

  always #5 clk = ~clk;

  imem_boot_loader_if if0 ();
  imem_boot_loader_if if1 ();

  assign if0.start    = start;
  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if1.start    = start;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;

  imem_boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  imem_boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_nbytes = 0; m_acc = '0; m_have_hdr = 0; m_n = 0; m_words = 0;
    m_wr_now = 0; m_wd = '0; m_done = 0; m_err = 0;
  endtask

  function automatic bit m_ready();
    return !m_done && !m_err && !m_wr_now;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    if (rst) model_clear();
    else if (m_done || m_err) begin
      if (start) model_clear();
    end else if (m_wr_now) begin
      m_wr_now = 0;
      m_words++;
      if (m_words == m_n) m_done = 1;
    end else if (in_valid) begin
      m_acc = m_acc | (32'(in_data) << (8 * m_nbytes));
      m_nbytes++;
      if (m_nbytes == 4) begin
        if (!m_have_hdr) begin
          if (m_acc == 32'd0 || m_acc > 32'(DEPTH)) m_err = 1;
          else begin
            m_have_hdr = 1;
            m_n = int'(m_acc);
          end
        end else begin
          m_wr_now = 1;
          m_wd = m_acc;
        end
        m_acc = '0;
        m_nbytes = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [4:0] exp_st;
    exp_st = {m_ready(), m_wr_now, m_done, m_err, m_done};
    chk("status0", 32'({if0.in_ready, if0.we, if0.done, if0.err, if0.core_rst_n}), 32'(exp_st));
    chk("status1", 32'({if1.in_ready, if1.we, if1.done, if1.err, if1.core_rst_n}), 32'(exp_st));
    if (if0.we) wr_log.push_back({if0.wa, if0.wd});
    if (if1.we) last_wa1 = if1.wa;
    if (m_wr_now) begin
      chk("wa0", if0.wa, BASE0 + 32'(4 * m_words));
      chk("wd0", if0.wd, m_wd);
      chk("wa1", if1.wa, BASE1 + 32'(4 * m_words));
      chk("wd1", if1.wd, m_wd);
    end
  endtask

  task automatic tick();
    if (rnd_start_en) start = ($urandom_range(0, 5) == 0);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rnd_start_en = 0; start = 0; in_valid = 0; in_data = '0; rst = 1'b1;
    tick();
    chk("rst_wa0", if0.wa, BASE0);
    chk("rst_wa1", if1.wa, BASE1);
    chk("rst_wd0", if0.wd, 32'h0);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      acc = m_ready();
      tick();
      n++;
    end while (!acc && n < 8);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_byte timeout byte=%h t=%0t", b, $time);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_data = 8'($urandom);
        idle($urandom_range(1, 2));
      end
      send_byte(v[7:0]);
      v = v >> 8;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    hdr_vec_t    vecs[8];
    logic [7:0]  t1[12];
    logic [7:0]  b3[4];
    logic [6:0]  pat;
    int          k;
    int          nlog;
    int          nw;
    bit          acc;
    bit          bad;

    vecs[0] = '{hdr: 32'h0000_0000, exp_err: 1'b1};
    vecs[1] = '{hdr: 32'h0000_0401, exp_err: 1'b1};
    vecs[2] = '{hdr: 32'h0000_0400, exp_err: 1'b0};
    vecs[3] = '{hdr: 32'h0000_0001, exp_err: 1'b0};
    vecs[4] = '{hdr: 32'h0000_0800, exp_err: 1'b1};
    vecs[5] = '{hdr: 32'h0001_0001, exp_err: 1'b1};
    vecs[6] = '{hdr: 32'hFFFF_FFFF, exp_err: 1'b1};
    vecs[7] = '{hdr: 32'h0000_03FF, exp_err: 1'b0};
    t1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h23, 8'hA4, 8'h64, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF};
    b3 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    pat = 7'b1101001;
    last_wa1 = '0;
    model_clear();

    // 1: two-word image
    do_reset();
    wr_log.delete();
    for (int i = 0; i < 12; i++) send_byte(t1[i]);
    idle(3);
    chk("t1_nwe", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      chk("t1_w0", wr_log[0][31:0], 32'h0064_A423);
      chk("t1_a0", wr_log[0][63:32], 32'h0000_0000);
      chk("t1_w1", wr_log[1][31:0], 32'hFFC4_A303);
      chk("t1_a1", wr_log[1][63:32], 32'h0000_0004);
    end
    chk("t1_done", 32'(if0.done), 32'd1);
    chk("t1_core_rst_n", 32'(if0.core_rst_n), 32'd1);

    // 2: header table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      nlog = wr_log.size();
      send_word(vecs[i].hdr, 1'b0);
      in_valid = 1'b0;
      chk("hdr_err", 32'(if0.err), 32'(vecs[i].exp_err));
      chk("hdr_ready", 32'(if0.in_ready), 32'(!vecs[i].exp_err));
      chk("hdr_core_rst_n", 32'(if0.core_rst_n), 32'd0);
      idle(2);
      chk("hdr_nowe", 32'(wr_log.size()), 32'(nlog));
      if (vecs[i].exp_err) begin
        pulse_start();
        chk("hdr_rearm_err", 32'(if0.err), 32'd0);
        chk("hdr_rearm_ready", 32'(if0.in_ready), 32'd1);
      end
    end

    // 3: N=1 with valid gaps
    do_reset();
    nlog = wr_log.size();
    send_word(32'd1, 1'b0);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_data  = (k < 4) ? b3[k] : 8'h00;
      acc = pat[i] && m_ready();
      tick();
      if (acc) k++;
    end
    idle(3);
    chk("t3_nwe", 32'(wr_log.size()), 32'(nlog + 1));
    chk("t3_wd", wr_log[$][31:0], 32'hDEAD_BEEF);
    chk("t3_done", 32'(if0.done), 32'd1);

    // 4: reset in the middle of word 1, then a fresh frame
    do_reset();
    send_word(32'd2, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    send_word(32'd1, 1'b0);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    chk("t4_wd", wr_log[$][31:0], 32'h0000_0513);
    chk("t4_wa", wr_log[$][63:32], 32'h0000_0000);

    // 5: re-arm from DONE
    pulse_start();
    chk("t5_core_rst_n", 32'(if0.core_rst_n), 32'd0);
    chk("t5_done_clr", 32'(if0.done), 32'd0);
    send_word(32'd1, 1'b0);
    send_word(32'h0000_02B3, 1'b0);
    idle(2);
    chk("t5_wd", wr_log[$][31:0], 32'h0000_02B3);
    chk("t5_wa", wr_log[$][63:32], 32'h0000_0000);
    chk("t5_done", 32'(if0.done), 32'd1);

    // Randomized frames with gaps and stray start pulses
    for (int f = 0; f < 25; f++) begin
      rnd_start_en = 0; start = 0;
      if ($urandom_range(0, 4) == 0) do_reset();
      else if (m_done || m_err) pulse_start();
      bad = ($urandom_range(0, 4) == 0);
      if (bad) nw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1025, 70000));
      else     nw = int'($urandom_range(1, 6));
      rnd_start_en = 1;
      send_word(32'(nw), 1'b1);
      if (!bad) for (int w = 0; w < nw; w++) send_word($urandom, 1'b1);
      rnd_start_en = 0; start = 0;
      idle(3);
    end

    // 6: full-depth image (second instance has base 0x100)
    do_reset();
    wr_log.delete();
    send_word(32'(DEPTH), 1'b0);
    for (int w = 0; w < int'(DEPTH); w++) send_word($urandom, 1'b0);
    idle(3);
    chk("t6_nwe", 32'(wr_log.size()), 32'(DEPTH));
    chk("t6_last_wa0", wr_log[$][63:32], 32'h0000_0FFC);
    chk("t6_last_wa1", last_wa1, 32'h0000_10FC);
    chk("t6_done", 32'(if1.done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
